// File: rtl/float_to_fixed_arbiter.sv
// Round-robin share of one float-to-fixed converter with tagged result FIFO.
// Define FLOAT_TO_FIXED_ARB_SPECIAL_FLAG_EN to carry the Inf/NaN flag.
module float_to_fixed_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int FIXED_WIDTH = 12,
  parameter int CONV_LAT    = 3,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*32-1:0]      req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [31:0]                conv_a,
  input  logic [FIXED_WIDTH-1:0]     conv_q,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [$clog2(NUM_REQ)-1:0] res_id,
  output logic [FIXED_WIDTH-1:0]     res_q,
  output logic                       res_flag,
  output logic                       busy
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int UW  = $clog2(FIFO_DEPTH + CONV_LAT + 1);

  logic [IDW-1:0]         r_rr;
  logic [IDW-1:0]         w_gid;
  logic [2*NUM_REQ-1:0]   w_dbl;
  logic                   w_hit;
  logic                   w_room;
  logic                   w_issue;
  int                     w_j;
  logic [UW-1:0]          w_infl;

  logic [CONV_LAT-1:0]    r_vld;
  logic [IDW-1:0]         r_tid [CONV_LAT];

  logic [IDW-1:0]         r_fid [FIFO_DEPTH];
  logic [FIXED_WIDTH-1:0] r_fq  [FIFO_DEPTH];
  logic [AW-1:0]          r_wp;
  logic [AW-1:0]          r_rp;
  logic [CW-1:0]          r_cnt;
  logic                   w_push;
  logic                   w_pop;

  // Rotate the request vector so the search starts at rr_ptr.
  always_comb begin
    w_hit = 1'b0;
    w_j   = 0;
    w_dbl = {req_valid, req_valid} >> r_rr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_hit && w_dbl[k]) begin
        w_hit = 1'b1;
        w_j   = int'(r_rr) + k;
      end
    end
    if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
    w_gid = IDW'(w_j);
  end

  // Outstanding = FIFO entries plus in-flight tags; pops are not credited.
  always_comb begin
    w_infl = '0;
    for (int i = 0; i < CONV_LAT; i++) begin
      w_infl = w_infl + UW'(r_vld[i]);
    end
  end

  assign w_room  = (w_infl + UW'(r_cnt)) < UW'(FIFO_DEPTH);
  assign w_issue = w_hit && w_room && !rst;

  always_comb begin
    req_ready = '0;
    conv_a    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_issue && (w_gid == IDW'(i))) begin
        req_ready[i] = 1'b1;
        conv_a       = req_data[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr <= '0;
    end else if (w_issue) begin
      r_rr <= (w_gid == IDW'(NUM_REQ - 1)) ? '0 : w_gid + IDW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      for (int i = 0; i < CONV_LAT; i++) r_tid[i] <= '0;
    end else begin
      r_vld[0] <= w_issue;
      r_tid[0] <= w_gid;
      for (int i = 1; i < CONV_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_tid[i] <= r_tid[i-1];
      end
    end
  end

  assign w_push    = r_vld[CONV_LAT-1];
  assign res_valid = (r_cnt != '0);
  assign w_pop     = res_valid && res_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fid[r_wp] <= r_tid[CONV_LAT-1];
      r_fq[r_wp]  <= conv_q;
    end
  end

  assign res_id = res_valid ? r_fid[r_rp] : '0;
  assign res_q  = res_valid ? r_fq[r_rp]  : '0;
  assign busy   = (|r_vld) || res_valid;

`ifdef FLOAT_TO_FIXED_ARB_SPECIAL_FLAG_EN
  logic                  w_flag;
  logic [CONV_LAT-1:0]   r_tfl;
  logic [FIFO_DEPTH-1:0] r_ffl;

  assign w_flag = &conv_a[30:23];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tfl <= '0;
    end else begin
      r_tfl[0] <= w_flag;
      for (int i = 1; i < CONV_LAT; i++) r_tfl[i] <= r_tfl[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_ffl[r_wp] <= r_tfl[CONV_LAT-1];
  end

  assign res_flag = res_valid && r_ffl[r_rp];
`else
  assign res_flag = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_no_ovf: assert (!(w_push && (r_cnt == CW'(FIFO_DEPTH))));
    end
  end
endmodule

// File: tb/tb_float_to_fixed_arbiter.sv
// Directed bench for float_to_fixed_arbiter with a queue-based reference model.
module tb_float_to_fixed_arbiter;
  localparam int N   = 4;
  localparam int FW  = 12;
  localparam int LAT = 3;
  localparam int DEP = 8;
`ifdef FLOAT_TO_FIXED_ARB_SPECIAL_FLAG_EN
  localparam bit FLAG_EN = 1'b1;
`else
  localparam bit FLAG_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*32-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic [31:0]   conv_a;
  logic [FW-1:0] conv_q;
  logic          res_valid;
  logic          res_ready;
  logic [1:0]    res_id;
  logic [FW-1:0] res_q;
  logic          res_flag;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;

  float_to_fixed_arbiter #(
    .NUM_REQ(N), .FIXED_WIDTH(FW), .CONV_LAT(LAT), .FIFO_DEPTH(DEP)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .conv_a(conv_a), .conv_q(conv_q),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_q(res_q), .res_flag(res_flag),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Truncate toward zero, saturate to the signed 12-bit range.
  function automatic logic [FW-1:0] f2fix(logic [31:0] f);
    int e;
    int mag;
    if (f[30:23] == 8'hFF)
      return (f[22:0] != 0) ? 12'h7FF : (f[31] ? 12'h800 : 12'h7FF);
    e = int'(f[30:23]) - 127;
    if (e < 0) return 12'h000;
    if (e >= 11) return f[31] ? 12'h800 : 12'h7FF;
    mag = int'({1'b1, f[22:0]}) >> (23 - e);
    return f[31] ? 12'(-mag) : 12'(mag);
  endfunction

  // Float with value v2/2.
  function automatic logic [31:0] fval(int v2);
    int m;
    int p;
    logic [31:0] r;
    if (v2 == 0) return 32'h0;
    m = (v2 < 0) ? -v2 : v2;
    p = 0;
    for (int b = 0; b < 31; b++) if (m[b]) p = b;
    r[31]    = (v2 < 0);
    r[30:23] = 8'(127 + p - 1);
    r[22:0]  = 23'(m << (23 - p));
    return r;
  endfunction

  function automatic logic [31:0] gen(int i, int k);
    int v2;
    v2 = (i + 1) * 20 + 2 * k + 1;
    return fval((k % 2 == 1) ? -v2 : v2);
  endfunction

  // Free-running converter.
  logic [FW-1:0] cp [LAT];
  always @(posedge clk) begin
    cp[0] <= f2fix(conv_a);
    for (int i = 1; i < LAT; i++) cp[i] <= cp[i-1];
  end
  assign conv_q = cp[LAT-1];

  typedef struct {
    logic [1:0]    id;
    logic [FW-1:0] q;
    logic          fl;
    int            rdy;
  } ent_t;

  ent_t         mq[$];
  int           mrr = 0;
  int           cyc = 0;
  logic [N-1:0] last_grant = '0;

  always @(negedge clk) begin
    int          eg;
    logic [31:0] ea;
    logic [N-1:0] er;
    bit          hv;
    ent_t        e;
    cyc++;
    if (rst) begin
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_conv_a", conv_a, 0);
      chk("rst_res_valid", 32'(res_valid), 0);
      chk("rst_res_id", 32'(res_id), 0);
      chk("rst_res_q", 32'(res_q), 0);
      chk("rst_res_flag", 32'(res_flag), 0);
      chk("rst_busy", 32'(busy), 0);
      mq.delete();
      mrr = 0;
      last_grant = '0;
    end else begin
      eg = -1;
      if (mq.size() < DEP) begin
        for (int k = 0; k < N; k++)
          if (eg < 0 && req_valid[(mrr + k) % N]) eg = (mrr + k) % N;
      end
      er = '0;
      ea = '0;
      if (eg >= 0) begin
        er[eg] = 1'b1;
        ea = req_data[32*eg +: 32];
      end
      hv = (mq.size() > 0) && (mq[0].rdy <= cyc);
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("conv_a", conv_a, ea);
      chk("res_valid", 32'(res_valid), 32'(hv));
      if (hv) begin
        chk("res_id", 32'(res_id), 32'(mq[0].id));
        chk("res_q", 32'(res_q), 32'(mq[0].q));
        chk("res_flag", 32'(res_flag), 32'(mq[0].fl));
      end else begin
        chk("idle_res_id", 32'(res_id), 0);
        chk("idle_res_q", 32'(res_q), 0);
        chk("idle_res_flag", 32'(res_flag), 0);
      end
      chk("busy", 32'(busy), 32'(mq.size() > 0));
      if (hv && res_ready) void'(mq.pop_front());
      if (eg >= 0) begin
        e.id  = 2'(eg);
        e.q   = f2fix(ea);
        e.fl  = FLAG_EN && (ea[30:23] == 8'hFF);
        e.rdy = cyc + LAT + 1;
        mq.push_back(e);
        mrr = (eg + 1) % N;
      end
      last_grant = er;
    end
  end

  bit auto_m = 1'b0;
  int kc [N];
  int acc;

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (last_grant[i]) begin
        if (auto_m) begin
          kc[i]++;
          req_data[32*i +: 32] = gen(i, kc[i]);
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic start_auto();
    auto_m = 1'b1;
    for (int i = 0; i < N; i++) begin
      kc[i] = 0;
      req_data[32*i +: 32] = gen(i, 0);
    end
    req_valid = '1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    auto_m    = 1'b0;
    rst       = 1'b1;
    tick();
    tick();
    rst       = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single request: 5.0 from requester 0.
    res_ready = 1'b1;
    req_data[31:0] = 32'h40A0_0000;
    req_valid = 4'b0001;
    @(negedge clk);
    chk("t1_grant", 32'(req_ready), 32'h1);
    tick(); tick(); tick();
    @(negedge clk);
    chk("t1_early", 32'(res_valid), 0);
    tick();
    @(negedge clk);
    chk("t1_valid", 32'(res_valid), 1);
    chk("t1_id", 32'(res_id), 0);
    chk("t1_q", 32'(res_q), 5);
    tick();

    // All requesters valid: back-to-back rotation.
    do_reset();
    res_ready = 1'b1;
    start_auto();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("t2_rotate", 32'(req_ready), 32'(1 << (k % 4)));
      tick();
    end
    req_valid = '0;
    repeat (6) tick();

    // Back-pressure: credit stops issue after FIFO_DEPTH accepts.
    do_reset();
    res_ready = 1'b0;
    start_auto();
    acc = 0;
    repeat (16) begin
      @(negedge clk);
      if (req_ready != '0) acc++;
      tick();
    end
    chk("t3_accepts", acc, 8);
    @(negedge clk);
    chk("t3_stall", 32'(req_ready), 0);
    tick();
    res_ready = 1'b1;
    @(negedge clk);
    chk("t3_no_pop_credit", 32'(req_ready), 0);
    chk("t3_head", 32'(res_valid), 1);
    tick();
    @(negedge clk);
    chk("t3_resume", 32'(req_ready), 32'h1);
    repeat (12) tick();
    req_valid = '0;
    auto_m    = 1'b0;
    repeat (14) tick();

    // rr_ptr=2 with requesters 1 and 3 pending.
    do_reset();
    res_ready = 1'b1;
    req_data[31:0]  = fval(-7);
    req_data[63:32] = fval(9);
    req_valid = 4'b0011;
    @(negedge clk);
    chk("t4_g0", 32'(req_ready), 32'h1);
    tick();
    @(negedge clk);
    chk("t4_g1", 32'(req_ready), 32'h2);
    tick();
    req_data[63:32]  = fval(-4001);
    req_data[127:96] = fval(6000);
    req_valid = 4'b1010;
    @(negedge clk);
    chk("t4_g3_first", 32'(req_ready), 32'h8);
    tick();
    @(negedge clk);
    chk("t4_g1_next", 32'(req_ready), 32'h2);
    tick();

    // +Inf from requester 2.
    req_data[95:64] = 32'h7F80_0000;
    req_valid = 4'b0100;
    @(negedge clk);
    chk("t5_grant", 32'(req_ready), 32'h4);
    tick(); tick(); tick(); tick();
    @(negedge clk);
    chk("t5_valid", 32'(res_valid), 1);
    chk("t5_id", 32'(res_id), 2);
    chk("t5_q", 32'(res_q), 32'h7FF);
    chk("t5_flag", 32'(res_flag), 32'(FLAG_EN));
    repeat (4) tick();

    // Reset one cycle after two accepts drops both.
    req_data[31:0]  = fval(21);
    req_data[63:32] = fval(-33);
    req_valid = 4'b0011;
    @(negedge clk);
    chk("t6_acc0", 32'(|req_ready), 1);
    tick();
    @(negedge clk);
    chk("t6_acc1", 32'(|req_ready), 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_nores", 32'(res_valid), 0);
    repeat (6) begin
      tick();
      @(negedge clk);
      chk("t6_nores", 32'(res_valid), 0);
    end
    tick();
    start_auto();
    @(negedge clk);
    chk("t6_grant0", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    auto_m    = 1'b0;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
